// File: rtl/cbus_arbiter_if.sv
// Bundled request, completion and memory-port signals of the cbus arbiter.
// slave: arbiter side; master: core masters plus memory model side.
interface cbus_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic                  i_valid;
    logic [ADDR_W-1:0]     i_addr;
    logic                  i_data_ok;
    logic [31:0]           i_data;

    logic                  d_valid;
    logic [ADDR_W-1:0]     d_addr;
    logic [2:0]            d_size;
    logic [DATA_W/8-1:0]   d_strobe;
    logic [DATA_W-1:0]     d_wdata;
    logic                  d_data_ok;
    logic [DATA_W-1:0]     d_data;

    logic                  mem_valid;
    logic [ADDR_W-1:0]     mem_addr;
    logic [2:0]            mem_size;
    logic [DATA_W/8-1:0]   mem_strobe;
    logic [DATA_W-1:0]     mem_wdata;
    logic                  mem_ok;
    logic [DATA_W-1:0]     mem_rdata;

    modport slave (
        input  i_valid, i_addr, d_valid, d_addr, d_size, d_strobe, d_wdata, mem_ok, mem_rdata,
        output i_data_ok, i_data, d_data_ok, d_data,
               mem_valid, mem_addr, mem_size, mem_strobe, mem_wdata
    );

    modport master (
        output i_valid, i_addr, d_valid, d_addr, d_size, d_strobe, d_wdata, mem_ok, mem_rdata,
        input  i_data_ok, i_data, d_data_ok, d_data,
               mem_valid, mem_addr, mem_size, mem_strobe, mem_wdata
    );
endinterface

// File: rtl/cbus_arbiter.sv
// ibus/dbus to single memory port arbiter; dbus priority, round-robin with CBUS_ARB_RR_EN.
// Latency: grant at the edge after valid, data_ok in the same cycle as mem_ok.
// Backpressure: one transaction in flight; requests wait in IDLE until the port is free.
module cbus_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic           clk,
    input  logic           reset,
    cbus_arbiter_if.slave  bus
);
    localparam int         STRB_W    = DATA_W / 8;
    localparam logic [2:0] IBUS_SIZE = 3'b010;

    typedef enum logic {IDLE, BUSY} state_e;

    state_e              state_q, state_d;
    logic                grant_q, grant_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [2:0]          size_q, size_d;
    logic [STRB_W-1:0]   strobe_q, strobe_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                sel;
    logic                grant_now;
    logic                done;

`ifdef CBUS_ARB_RR_EN
    logic last_q;

    // On contention the master that did not win last time goes first.
    assign sel = (bus.i_valid && bus.d_valid) ? ~last_q : bus.d_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= 1'b1;
        end else if (grant_now) begin
            last_q <= sel;
        end
    end
`else
    assign sel = bus.d_valid;
`endif

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        addr_d    = addr_q;
        size_d    = size_q;
        strobe_d  = strobe_q;
        wdata_d   = wdata_q;
        grant_now = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.i_valid || bus.d_valid) begin
                    grant_now = 1'b1;
                    state_d   = BUSY;
                    grant_d   = sel;
                    if (sel) begin
                        addr_d   = bus.d_addr;
                        size_d   = bus.d_size;
                        strobe_d = bus.d_strobe;
                        wdata_d  = bus.d_wdata;
                    end else begin
                        addr_d   = bus.i_addr;
                        size_d   = IBUS_SIZE;
                        strobe_d = '0;
                        wdata_d  = '0;
                    end
                end
            end
            BUSY: begin
                if (bus.mem_ok) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            grant_q  <= 1'b0;
            addr_q   <= '0;
            size_q   <= '0;
            strobe_q <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            strobe_q <= strobe_d;
            wdata_q  <= wdata_d;
        end
    end

    assign bus.mem_valid  = (state_q == BUSY);
    assign bus.mem_addr   = addr_q;
    assign bus.mem_size   = size_q;
    assign bus.mem_strobe = strobe_q;
    assign bus.mem_wdata  = wdata_q;

    // Read data is zeroed outside the completion pulse so idle outputs stay quiet.
    assign bus.i_data_ok = done & ~grant_q;
    assign bus.d_data_ok = done &  grant_q;
    assign bus.i_data    = bus.i_data_ok ? bus.mem_rdata[31:0] : 32'h0;
    assign bus.d_data    = bus.d_data_ok ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_cbus_arbiter.sv
// Randomized and directed checks of cbus_arbiter against a transaction-level model.
module tb_cbus_arbiter;
    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
`ifdef CBUS_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cbus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
    cbus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_pass  = 0;
    int n_total = 0;
    bit m_last;

    // Winner of one arbitration round: 1 = dbus, 0 = ibus.
    function automatic bit pick(input bit iv, input bit dv, input bit last);
        if (iv && dv) return RR ? ~last : 1'b1;
        return dv;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.i_valid = 0; bus.i_addr = '0;
        bus.d_valid = 0; bus.d_addr = '0; bus.d_size = '0; bus.d_strobe = '0; bus.d_wdata = '0;
        bus.mem_ok = 0; bus.mem_rdata = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        m_last = 1'b1;
        tick(); tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.mem_ok = 1'b1;
        bus.mem_rdata = {$urandom, $urandom};
        #1;
        n_total++; if (bus.mem_valid !== 1'b0) $display("FAIL reset_mem_valid got=%b exp=0", bus.mem_valid); else n_pass++;
        n_total++; if ({bus.i_data_ok, bus.d_data_ok} !== 2'b00) $display("FAIL reset_data_ok got=%b exp=00", {bus.i_data_ok, bus.d_data_ok}); else n_pass++;
        n_total++; if ({bus.mem_addr, bus.mem_size, bus.mem_strobe, bus.mem_wdata} !== '0)
            $display("FAIL reset_mem_fields got=%h/%h/%h/%h exp=0", bus.mem_addr, bus.mem_size, bus.mem_strobe, bus.mem_wdata); else n_pass++;
        n_total++; if ({bus.i_data, bus.d_data} !== '0) $display("FAIL reset_data got=%h/%h exp=0", bus.i_data, bus.d_data); else n_pass++;
        do_reset();
    endtask

    task automatic test_single_ibus();
        logic [63:0] r;
        do_reset();
        tick(); bus.i_valid = 1; bus.i_addr = 64'h8000_0000; #1;
        n_total++; if (bus.mem_valid !== 1'b0) $display("FAIL ibus_c0_mem_valid got=%b exp=0", bus.mem_valid); else n_pass++;
        tick();
        n_total++; if (bus.mem_valid !== 1'b1) $display("FAIL ibus_c1_mem_valid got=%b exp=1", bus.mem_valid); else n_pass++;
        n_total++; if (bus.mem_addr !== 64'h8000_0000) $display("FAIL ibus_c1_addr got=%h exp=80000000", bus.mem_addr); else n_pass++;
        n_total++; if ({bus.mem_strobe, bus.mem_size} !== {8'h00, 3'b010}) $display("FAIL ibus_c1_strb_size got=%h/%b exp=00/010", bus.mem_strobe, bus.mem_size); else n_pass++;
        tick();
        n_total++; if (bus.i_data_ok !== 1'b0) $display("FAIL ibus_c2_data_ok got=%b exp=0", bus.i_data_ok); else n_pass++;
        tick(); r = {$urandom, $urandom}; bus.mem_ok = 1; bus.mem_rdata = r; #1;
        n_total++; if ({bus.i_data_ok, bus.d_data_ok} !== 2'b10) $display("FAIL ibus_c3_data_ok got=%b exp=10", {bus.i_data_ok, bus.d_data_ok}); else n_pass++;
        n_total++; if (bus.i_data !== r[31:0]) $display("FAIL ibus_c3_data got=%h exp=%h", bus.i_data, r[31:0]); else n_pass++;
        tick(); bus.mem_ok = 0; bus.i_valid = 0; #1;
        n_total++; if ({bus.mem_valid, bus.i_data_ok} !== 2'b00) $display("FAIL ibus_c4_idle got=%b exp=00", {bus.mem_valid, bus.i_data_ok}); else n_pass++;
    endtask

    task automatic test_contention();
        bit first;
        logic [63:0] ia, da;
        do_reset();
        ia = {$urandom, $urandom}; da = {$urandom, $urandom};
        tick();
        bus.i_valid = 1; bus.i_addr = ia;
        bus.d_valid = 1; bus.d_addr = da; bus.d_strobe = 8'hFF; bus.d_size = 3'b011; bus.d_wdata = {$urandom, $urandom};
        first = pick(1'b1, 1'b1, m_last);
        for (int t = 0; t < 2; t++) begin
            bit who;
            who = (t == 0) ? first : ~first;
            tick(); bus.mem_ok = 1; bus.mem_rdata = {$urandom, $urandom}; #1;
            n_total++; if (bus.mem_addr !== (who ? da : ia)) $display("FAIL cont%0d_addr got=%h exp=%h", t, bus.mem_addr, who ? da : ia); else n_pass++;
            n_total++; if (bus.mem_strobe !== (who ? 8'hFF : 8'h00)) $display("FAIL cont%0d_strobe got=%h exp=%h", t, bus.mem_strobe, who ? 8'hFF : 8'h00); else n_pass++;
            n_total++; if ({bus.i_data_ok, bus.d_data_ok} !== {~who, who}) $display("FAIL cont%0d_data_ok got=%b exp=%b", t, {bus.i_data_ok, bus.d_data_ok}, {~who, who}); else n_pass++;
            tick(); bus.mem_ok = 0;
            if (who) bus.d_valid = 0; else bus.i_valid = 0;
            #1;
            n_total++; if (bus.mem_valid !== 1'b0) $display("FAIL cont%0d_gap got=%b exp=0", t, bus.mem_valid); else n_pass++;
        end
        clear_inputs();
    endtask

    task automatic test_continuous();
        logic [63:0] ia, da, r;
        int lat;
        bit exp;
        do_reset();
        ia = {$urandom, $urandom}; da = {$urandom, $urandom};
        tick(); bus.i_valid = 1; bus.i_addr = ia; bus.d_valid = 1; bus.d_addr = da; bus.d_strobe = 8'h0F;
        for (int t = 0; t < 6; t++) begin
            exp = pick(1'b1, 1'b1, m_last);
            m_last = exp;
            lat = $urandom_range(1, 3);
            for (int c = 1; c <= lat; c++) begin
                tick(); r = {$urandom, $urandom}; bus.mem_ok = (c == lat); bus.mem_rdata = r; #1;
            end
            n_total++; if (bus.mem_addr !== (exp ? da : ia)) $display("FAIL seq%0d_addr got=%h exp=%h", t, bus.mem_addr, exp ? da : ia); else n_pass++;
            n_total++; if ({bus.i_data_ok, bus.d_data_ok} !== {~exp, exp}) $display("FAIL seq%0d_grant got=%b exp=%b", t, {bus.i_data_ok, bus.d_data_ok}, {~exp, exp}); else n_pass++;
            tick(); bus.mem_ok = 0;
            if (exp) begin da = {$urandom, $urandom}; bus.d_addr = da; end
            else begin ia = {$urandom, $urandom}; bus.i_addr = ia; end
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        tick(); bus.d_valid = 1; bus.d_addr = 64'h1234; bus.d_strobe = 8'h01;
        tick(); tick(); bus.d_valid = 0;
        reset = 1'b0; #1;
        n_total++; if (bus.mem_valid !== 1'b0) $display("FAIL rstmid_mem_valid got=%b exp=0", bus.mem_valid); else n_pass++;
        tick(); reset = 1'b1;
        tick(); bus.mem_ok = 1; bus.mem_rdata = {$urandom, $urandom}; #1;
        n_total++; if ({bus.i_data_ok, bus.d_data_ok, bus.mem_valid} !== 3'b000)
            $display("FAIL rstmid_late_ok got=%b exp=000", {bus.i_data_ok, bus.d_data_ok, bus.mem_valid}); else n_pass++;
        tick(); bus.mem_ok = 0; #1;
        n_total++; if (bus.mem_valid !== 1'b0) $display("FAIL rstmid_after got=%b exp=0", bus.mem_valid); else n_pass++;
    endtask

    task automatic test_drop_valid();
        logic [63:0] r;
        do_reset();
        tick(); bus.d_valid = 1; bus.d_addr = 64'hABCD_0000;
        tick(); bus.d_valid = 0; #1;
        n_total++; if (bus.mem_valid !== 1'b1) $display("FAIL drop_c1_mem_valid got=%b exp=1", bus.mem_valid); else n_pass++;
        tick(); r = {$urandom, $urandom}; bus.mem_ok = 1; bus.mem_rdata = r; #1;
        n_total++; if (bus.d_data_ok !== 1'b1) $display("FAIL drop_c2_data_ok got=%b exp=1", bus.d_data_ok); else n_pass++;
        n_total++; if (bus.d_data !== r) $display("FAIL drop_c2_data got=%h exp=%h", bus.d_data, r); else n_pass++;
        tick(); bus.mem_ok = 0; #1;
        n_total++; if ({bus.mem_valid, bus.d_data_ok} !== 2'b00) $display("FAIL drop_c3_idle got=%b exp=00", {bus.mem_valid, bus.d_data_ok}); else n_pass++;
    endtask

    task automatic test_addr_change();
        logic [63:0] a;
        logic [7:0]  s;
        do_reset();
        a = {$urandom, $urandom}; s = 8'($urandom_range(1, 255));
        tick(); bus.d_valid = 1; bus.d_addr = a; bus.d_strobe = s;
        for (int c = 1; c <= 4; c++) begin
            tick(); bus.d_addr = {$urandom, $urandom}; bus.d_strobe = 8'($urandom); bus.mem_ok = (c == 4); #1;
            n_total++; if ({bus.mem_addr, bus.mem_strobe} !== {a, s})
                $display("FAIL hold_c%0d got=%h/%h exp=%h/%h", c, bus.mem_addr, bus.mem_strobe, a, s); else n_pass++;
        end
        tick(); clear_inputs();
    endtask

    task automatic test_random();
        bit m_busy, m_owner, i_pend, d_pend, eo_i, eo_d;
        int m_cnt, m_lat;
        logic [63:0] m_addr, m_wdata;
        logic [2:0]  m_size;
        logic [7:0]  m_strobe;
        int errs;
        do_reset();
        m_busy = 0; i_pend = 0; d_pend = 0; m_cnt = 0; m_lat = 1; m_owner = 0;
        m_addr = '0; m_wdata = '0; m_size = '0; m_strobe = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            tick();
            if (!i_pend) bus.i_valid = 0;
            if (!d_pend) bus.d_valid = 0;
            if (!i_pend && $urandom_range(0, 2) == 0) begin
                i_pend = 1; bus.i_valid = 1; bus.i_addr = {$urandom, $urandom};
            end
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend = 1; bus.d_valid = 1; bus.d_addr = {$urandom, $urandom};
                bus.d_size = 3'($urandom); bus.d_strobe = 8'($urandom); bus.d_wdata = {$urandom, $urandom};
            end
            if (m_busy && $urandom_range(0, 1) == 0) begin
                if (m_owner) bus.d_addr = {$urandom, $urandom}; else bus.i_addr = {$urandom, $urandom};
            end
            if (m_busy) m_cnt++;
            bus.mem_ok = m_busy ? (m_cnt == m_lat) : ($urandom_range(0, 3) == 0);
            bus.mem_rdata = {$urandom, $urandom};
            #1;
            eo_i = m_busy && bus.mem_ok && !m_owner;
            eo_d = m_busy && bus.mem_ok && m_owner;
            errs = 0;
            if (bus.mem_valid !== m_busy) errs++;
            if ({bus.i_data_ok, bus.d_data_ok} !== {eo_i, eo_d}) errs++;
            if (m_busy && {bus.mem_addr, bus.mem_size, bus.mem_strobe} !== {m_addr, m_size, m_strobe}) errs++;
            if (eo_d && (bus.mem_wdata !== m_wdata || bus.d_data !== bus.mem_rdata)) errs++;
            if (eo_i && bus.i_data !== bus.mem_rdata[31:0]) errs++;
            n_total++;
            if (errs != 0)
                $display("FAIL rand_cyc%0d got vld=%b ok=%b%b addr=%h exp vld=%b ok=%b%b addr=%h",
                         cyc, bus.mem_valid, bus.i_data_ok, bus.d_data_ok, bus.mem_addr, m_busy, eo_i, eo_d, m_addr);
            else n_pass++;
            if (m_busy) begin
                if (bus.mem_ok) begin
                    m_busy = 0;
                    if (m_owner) d_pend = 0; else i_pend = 0;
                end
            end else if (bus.i_valid || bus.d_valid) begin
                m_owner = pick(bus.i_valid, bus.d_valid, m_last);
                m_last  = m_owner;
                m_busy  = 1; m_cnt = 0; m_lat = $urandom_range(1, 4);
                if (m_owner) begin
                    m_addr = bus.d_addr; m_size = bus.d_size; m_strobe = bus.d_strobe; m_wdata = bus.d_wdata;
                end else begin
                    m_addr = bus.i_addr; m_size = 3'b010; m_strobe = 8'h00; m_wdata = '0;
                end
            end
        end
        tick(); clear_inputs();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        clear_inputs();
        reset = 1'b1;
        m_last = 1'b1;
        test_reset();
        test_single_ibus();
        test_contention();
        test_continuous();
        test_reset_mid();
        test_drop_valid();
        test_addr_change();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
